// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: owner encoding, default widths, response tag.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  // One in-flight read slot: whether a response is due and who gets it
  typedef struct packed {
    logic valid;
    logic owner;
  } resp_tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester + memory-port bundle; master = pipeline/memory environment, slave = arbiter.
interface mem_port_arbiter_if import mem_port_arbiter_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_resp_tag_pipe.sv
// Fixed-latency {valid, owner} shift register steering read responses back to their requester.
module arb_resp_tag_pipe import mem_port_arbiter_pkg::*; #(
  parameter int unsigned DEPTH = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  resp_tag_t tag_in,
  output resp_tag_t tag_out
);

  resp_tag_t [DEPTH-1:0] stage_q;
  resp_tag_t [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = tag_in;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, D-priority with IF anti-starvation.
// Optional ARB_PERF_EN adds perf_conflicts / perf_if_stalls counters.
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]       perf_conflicts,
  output logic [31:0]       perf_if_stalls
`endif
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic             if_win;
  logic             d_win;
  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  resp_tag_t        tag_in;
  resp_tag_t        tag_out;

  // Winner select: D by default, IF once it has waited STARVE_MAX D grants
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (!rst) begin
      if (bus.if_req && (!bus.d_req || starve_q == CNT_W'(STARVE_MAX))) if_win = 1'b1;
      else if (bus.d_req)                                              d_win  = 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (if_win || !bus.if_req)                            starve_d = '0;
    else if (d_win && starve_q != CNT_W'(STARVE_MAX))     starve_d = starve_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  assign bus.if_gnt = if_win;
  assign bus.d_gnt  = d_win;

  // Memory port mux; idle drives everything low
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = {BE_W{1'b0}};
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    if (if_win) begin
      bus.mem_en   = 1'b1;
      bus.mem_be   = {BE_W{1'b1}};
      bus.mem_addr = bus.if_addr;
    end else if (d_win) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.d_we;
      bus.mem_be    = bus.d_be;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end
  end

  always_comb begin
    tag_in.valid = if_win | (d_win & ~bus.d_we);
    tag_in.owner = d_win ? OWNER_D : OWNER_IF;
  end

  arb_resp_tag_pipe #(.DEPTH(MEM_LATENCY)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Responses are masked while reset is asserted so stale tags never surface
  assign bus.if_rvalid = ~rst & tag_out.valid & (tag_out.owner == OWNER_IF);
  assign bus.d_rvalid  = ~rst & tag_out.valid & (tag_out.owner == OWNER_D);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

`ifdef ARB_PERF_EN
  logic [31:0] conflicts_q, conflicts_d;
  logic [31:0] stalls_q, stalls_d;

  always_comb begin
    conflicts_d = conflicts_q;
    stalls_d    = stalls_q;
    if (bus.if_req && bus.d_req) conflicts_d = conflicts_q + 32'd1;
    if (bus.if_req && !if_win)   stalls_d    = stalls_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflicts_q <= '0;
      stalls_q    <= '0;
    end else begin
      conflicts_q <= conflicts_d;
      stalls_q    <= stalls_d;
    end
  end

  assign perf_conflicts = conflicts_q;
  assign perf_if_stalls = stalls_q;
`endif

endmodule
